alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Sequencing controller that wraps the 16-bit ALU operations (add, subtract, multiply, shift) behind a single valid/ready request port and a single valid/ready result port. It accepts one operation at a time and latches its operands. Add, subtract and shift complete in one execute cycle. Multiply runs as a 16-step iterative shift-add sequence instead of one combinational array. The result is held until the consumer takes it. It sits between the instruction/issue logic and the ALU datapath, and it replaces per-op output buses (with high-Z on the unused ones) by one registered result bus.

Parameters:
WIDTH, 16, operand width; multiply step count equals WIDTH.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  request valid
in_ready  out  1  sequencer can accept a request
in_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 SHF
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cin  in  1  carry-in, used by ADD only
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_res  out  2*WIDTH  result
out_zero  out  1  out_res equals zero
busy  out  1  state is not IDLE
ops_done  out  CNT_W  count of completed result handshakes, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_res=0, out_zero=1, busy=0, ops_done=0, all internal operand, accumulator and step registers 0.
- Reset mid-operation: any in-flight operation is discarded with no partial result. IDLE is reached on the first edge with rst=1.
- in_ready = (state==IDLE), decoded combinationally from the state.
- A request is accepted on an edge where in_valid&&in_ready. Operands and op are latched on that edge.
- in_* values are ignored when in_ready=0. The sequencer never queues a second request.
- FSM states: IDLE, EXEC, MUL, DONE.
  - IDLE, on accept with op!=MUL: go to EXEC.
  - IDLE, on accept with op==MUL: go to MUL. Clear acc (WIDTH+1 bits), load mq=in_b, step=0.
  - EXEC: compute and register out_res, then go to DONE. Latency is 2 edges from the accept edge to out_valid visible.
  - MUL: one step per cycle.
    - If mq[0], sum = acc[WIDTH-1:0]+A as WIDTH+1 bits; otherwise sum = acc.
    - Then {acc,mq} = {sum,mq} >> 1.
    - After step WIDTH-1: out_res = {acc[WIDTH-1:0],mq}, go to DONE.
    - Latency is WIDTH+1 edges (17) from accept to out_valid visible.
  - DONE: out_valid=1, out_res and out_zero stable. On out_ready: go to IDLE and increment ops_done, which wraps to 0 after all-ones.
- Backpressure: while in DONE with out_ready=0, all outputs hold indefinitely.
- Back-to-back: in_ready returns 1 the cycle after the result handshake. Peak rate is one single-cycle op per 3 cycles.
- Arithmetic, all unsigned, upper unused result bits zero:
  - ADD: out_res = zero-extend(A+B+cin). Bit WIDTH is the carry-out.
  - SUB: result = B - A computed as B + ~A + 1. out_res[WIDTH-1:0] is the difference. out_res[WIDTH] is the carry-out (1 iff B>=A).
  - MUL: full 2*WIDTH unsigned product.
  - SHF: out_res = {A<<B, A>>B}, i.e. logical left shift in the upper half and logical right shift in the lower half. The full B is the shift amount, so B>=WIDTH gives 0 in both halves.
- out_zero is registered together with out_res.

Decomposition:
- Shared package alu_seq_pkg holds:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_SHF;
  - state encoding ST_IDLE, ST_EXEC, ST_MUL, ST_DONE;
  - MUL_STEPS = WIDTH.
- One sub-module, alu_seq_datapath, computes the single-cycle ADD/SUB/SHF results and the multiply step (acc, mq, A → next acc, mq). It has no state.
- FSM, counters and handshake stay in alu_op_sequencer.

Test Plan:
1. ADD A=0xFFFF B=0x0001 cin=1 → out_res=0x0001_0001, out_zero=0, out_valid 2 edges after accept, ops_done=1 after handshake.
2. SUB A=5 B=3 → out_res=0x0000_FFFE. SUB A=3 B=5 → out_res=0x0001_0002. SUB A=7 B=7 → out_res=0x0001_0000, out_zero=0.
3. MUL A=0xFFFF B=0xFFFF → out_res=0xFFFE_0001 after exactly 17 edges. in_ready=0 and busy=1 throughout; a second in_valid during MUL is dropped. MUL A=0 B=0x1234 → out_res=0, out_zero=1.
4. SHF A=0x8001 B=1 → out_res=0x0002_4000. SHF A=0x8001 B=16 → out_res=0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE → out_res, out_valid and ops_done stable. Release → one increment, in_ready=1 the next cycle.
6. Assert rst at MUL step 8 → next cycle state IDLE, out_valid=0, out_res=0, ops_done=0, in_ready=1. A following ADD 2+3 → out_res=5.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and sizing definitions for the ALU operation sequencer.
package alu_seq_pkg;

  localparam int unsigned SEQ_WIDTH = 16;
  localparam int unsigned SEQ_CNT_W = 16;
  localparam int unsigned OP_W      = 2;
  localparam int unsigned MUL_STEPS = SEQ_WIDTH;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_SHF = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request and result valid/ready ports of the ALU operation sequencer.
interface alu_op_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [OP_W-1:0]       in_op;
  logic [WIDTH-1:0]      in_a;
  logic [WIDTH-1:0]      in_b;
  logic                  in_cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*WIDTH-1:0]    out_res;
  logic                  out_zero;

  modport master (
    output in_valid, in_op, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_res, out_zero
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_res, out_zero
  );

endinterface

// File: rtl/alu_seq_datapath.sv
// Stateless arithmetic: single-cycle ADD/SUB/SHF results and one shift-add multiply step.
module alu_seq_datapath
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WIDTH
) (
  input  op_e                 op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                cin,
  input  logic [WIDTH:0]      acc,
  input  logic [WIDTH-1:0]    mq,
  output logic [2*WIDTH-1:0]  exec_res,
  output logic [WIDTH:0]      acc_nxt,
  output logic [WIDTH-1:0]    mq_nxt
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] sub_sum;
  logic [WIDTH:0] step_sum;

  always_comb begin
    add_sum  = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    // B - A as B + ~A + 1 so bit WIDTH is the no-borrow carry-out
    sub_sum  = {1'b0, b} + {1'b0, ~a} + (WIDTH+1)'(1);
    exec_res = '0;
    case (op)
      OP_ADD:  exec_res = (2*WIDTH)'(add_sum);
      OP_SUB:  exec_res = (2*WIDTH)'(sub_sum);
      OP_SHF:  exec_res = {a << b, a >> b};
      default: exec_res = '0;
    endcase

    step_sum = mq[0] ? ({1'b0, acc[WIDTH-1:0]} + {1'b0, a}) : acc;
    acc_nxt  = {1'b0, step_sum[WIDTH:1]};
    mq_nxt   = {step_sum[0], mq[WIDTH-1:1]};
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// One-at-a-time ALU op sequencer: latches a request, executes (iterative multiply), holds the result until taken.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WIDTH,
  parameter int unsigned CNT_W = SEQ_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave bus,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  localparam int unsigned STEP_W = $clog2(WIDTH);

  state_e               state;
  op_e                  op_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic                 cin_q;
  logic [WIDTH:0]       acc;
  logic [WIDTH-1:0]     mq;
  logic [STEP_W-1:0]    step;
  logic [2*WIDTH-1:0]   res_q;
  logic                 zero_q;
  logic                 valid_q;
  logic [CNT_W-1:0]     done_cnt;

  logic [2*WIDTH-1:0]   exec_res;
  logic [WIDTH:0]       acc_nxt;
  logic [WIDTH-1:0]     mq_nxt;

  alu_seq_datapath #(.WIDTH(WIDTH)) u_datapath (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .cin      (cin_q),
    .acc      (acc),
    .mq       (mq),
    .exec_res (exec_res),
    .acc_nxt  (acc_nxt),
    .mq_nxt   (mq_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      acc      <= '0;
      mq       <= '0;
      step     <= '0;
      res_q    <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
      done_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            op_q  <= op_e'(bus.in_op);
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            cin_q <= bus.in_cin;
            if (op_e'(bus.in_op) == OP_MUL) begin
              acc   <= '0;
              mq    <= bus.in_b;
              step  <= '0;
              state <= ST_MUL;
            end else begin
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          res_q   <= exec_res;
          zero_q  <= (exec_res == '0);
          valid_q <= 1'b1;
          state   <= ST_DONE;
        end
        ST_MUL: begin
          acc  <= acc_nxt;
          mq   <= mq_nxt;
          step <= step + STEP_W'(1);
          // Final step: product sits in the low WIDTH bits of acc and all of mq
          if (step == STEP_W'(WIDTH - 1)) begin
            res_q   <= {acc_nxt[WIDTH-1:0], mq_nxt};
            zero_q  <= ({acc_nxt[WIDTH-1:0], mq_nxt} == '0);
            valid_q <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            valid_q  <= 1'b0;
            done_cnt <= done_cnt + CNT_W'(1);
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign bus.out_valid = valid_q;
  assign bus.out_res   = res_q;
  assign bus.out_zero  = zero_q;
  assign ops_done      = done_cnt;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed-vector bench for alu_op_sequencer with hand-computed results and latencies.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] ops_done;
  logic [15:0] exp_done;
  int          n_cmp = 0;
  int          n_bad = 0;

  alu_op_sequencer_if bus ();

  alu_op_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input op_e op, input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Latency counts the accept edge as edge 1; optional poke drives a competing request meanwhile
  task automatic wait_result(input string tag, input int exp_lat, input logic [31:0] exp_res,
                             input logic exp_zero, input bit poke);
    int lat = 1;
    bit blocked = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.in_op    = OP_ADD;
        bus.in_a     = 16'h0001;
        bus.in_b     = 16'h0001;
        bus.in_cin   = 1'b0;
        if (!(bus.in_ready == 1'b0 && busy == 1'b1)) blocked = 1'b0;
      end
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_res"}, bus.out_res, exp_res);
    check_eq({tag, "_zero"}, 32'(bus.out_zero), 32'(exp_zero));
    if (poke) check_eq({tag, "_blocked"}, 32'(blocked), 32'd1);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_done++;
    check_eq({tag, "_ops_done"}, 32'(ops_done), 32'(exp_done));
    check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check_eq({tag, "_valid_clr"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bit stable;
    logic [31:0] held_res;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_ADD;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    exp_done      = '0;
    tick();
    tick();
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_res", bus.out_res, 32'd0);
    check_eq("rst_out_zero", 32'(bus.out_zero), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ops_done", 32'(ops_done), 32'd0);
    rst = 1'b0;
    tick();

    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b1);
    wait_result("add_carry", 2, 32'h0001_0001, 1'b0, 1'b0);
    handshake("add_carry");

    issue(OP_SUB, 16'd5, 16'd3, 1'b0);
    wait_result("sub_5_3", 2, 32'h0000_FFFE, 1'b0, 1'b0);
    handshake("sub_5_3");
    issue(OP_SUB, 16'd3, 16'd5, 1'b0);
    wait_result("sub_3_5", 2, 32'h0001_0002, 1'b0, 1'b0);
    handshake("sub_3_5");
    issue(OP_SUB, 16'd7, 16'd7, 1'b0);
    wait_result("sub_7_7", 2, 32'h0001_0000, 1'b0, 1'b0);
    handshake("sub_7_7");

    issue(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0);
    wait_result("mul_max", 17, 32'hFFFE_0001, 1'b0, 1'b1);
    handshake("mul_max");
    tick();
    check_eq("mul_no_queued_busy", 32'(busy), 32'd0);
    check_eq("mul_no_queued_valid", 32'(bus.out_valid), 32'd0);
    issue(OP_MUL, 16'h0000, 16'h1234, 1'b0);
    wait_result("mul_zero", 17, 32'h0000_0000, 1'b1, 1'b0);
    handshake("mul_zero");

    issue(OP_SHF, 16'h8001, 16'd1, 1'b0);
    wait_result("shf_1", 2, 32'h0002_4000, 1'b0, 1'b0);
    handshake("shf_1");
    issue(OP_SHF, 16'h8001, 16'd16, 1'b0);
    wait_result("shf_16", 2, 32'h0000_0000, 1'b1, 1'b0);
    handshake("shf_16");

    issue(OP_ADD, 16'd1, 16'd1, 1'b0);
    wait_result("bp", 2, 32'h0000_0002, 1'b0, 1'b0);
    held_res = bus.out_res;
    stable   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.out_res !== held_res || bus.out_valid !== 1'b1 || ops_done !== exp_done
          || bus.in_ready !== 1'b0) stable = 1'b0;
    end
    check_eq("bp_stable", 32'(stable), 32'd1);
    handshake("bp");

    issue(OP_MUL, 16'h1234, 16'h5678, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check_eq("mid_mul_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_done = '0;
    check_eq("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mrst_out_res", bus.out_res, 32'd0);
    check_eq("mrst_ops_done", 32'(ops_done), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    issue(OP_ADD, 16'd2, 16'd3, 1'b0);
    wait_result("post_rst_add", 2, 32'h0000_0005, 1'b0, 1'b0);
    handshake("post_rst_add");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
